// File: rtl/key_scan.sv
// ---------------------------------------------------------------------------
// key_scan: 4x4 matrix keypad scanner with debounce.
//
// Drives one keypad column low at a time and reads the active-low row lines.
// A press is accepted only after the captured row pattern has stayed stable
// for DEBOUNCE cycles. The accepted key is then published as
// key_code = row_idx*4 + col_idx, together with a one-cycle key_valid strobe.
// A release must also stay stable for DEBOUNCE cycles before scanning resumes
// from column 0.
//
// Optional feature (compile-time macro KEY_REPEAT_EN):
//   While a key is held, key_valid re-pulses every REPEAT_CYC cycles with
//   key_code unchanged. With the macro undefined the repeat logic is absent
//   and every accepted press gives exactly one key_valid.
//
// Parameters:
//   SCAN_DIV   - cycles each column stays driven (dwell), minimum 4
//   DEBOUNCE   - consecutive stable cycles to accept a press or a release
//   REPEAT_CYC - auto-repeat interval (KEY_REPEAT_EN builds only)
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   key_row   in   [3:0] keypad rows, active-low, asynchronous to clk
//   key_col   out  [3:0] column drive, active-low one-hot, registered
//   key_code  out  [3:0] last accepted key, registered
//   key_valid out  one-cycle strobe when key_code is (re)issued
//   key_down  out  high while the accepted key is held, through release debounce
// ---------------------------------------------------------------------------
module key_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 20000,
  parameter int REPEAT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  // Each counter is just wide enough for its own terminal count, so it can
  // never wrap: every one is cleared or parked when it hits that compare.
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [3:0]       ROWS_IDLE = 4'b1111;
  localparam logic [3:0]       COL0_DRV  = 4'b1110;

  // The synchroniser needs two row samples inside one dwell, and the row
  // sample at the end of a dwell must reflect the column being driven.
  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_CYC < 1) begin : g_bad_params
    $error("key_scan: SCAN_DIV must be >= 4, DEBOUNCE and REPEAT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    HOLD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  // Active-low one-hot drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Index of the lowest row held low; row 0 wins when several are pressed.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       row_m, row_s;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       col_cap, col_cap_nxt;
  logic [3:0]       row_cap, row_cap_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
  logic [3:0]       key_col_nxt, key_code_nxt;
  logic             key_valid_nxt, key_down_nxt;

  logic div_done, deb_done, rows_idle, rows_match;

  assign div_done   = (div_cnt == DIV_LAST);
  assign deb_done   = (deb_cnt == DEB_LAST);
  assign rows_idle  = (row_s == ROWS_IDLE);
  assign rows_match = (row_s == row_cap);

`ifdef KEY_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
  logic             rep_done;

  assign rep_done = (rep_cnt == REP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_cnt_nxt;
  end
`endif

  // Two-flop synchroniser for the asynchronous row lines. Resetting to all
  // ones keeps a reset from looking like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_m <= ROWS_IDLE;
      row_s <= ROWS_IDLE;
    end else begin
      row_m <= key_row;
      row_s <= row_m;
    end
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN:      if (div_done && !rows_idle) state_nxt = PRESS_DEB;
      PRESS_DEB: begin
        if (!rows_match)   state_nxt = SCAN;
        else if (deb_done) state_nxt = HOLD;
      end
      HOLD:      if (rows_idle) state_nxt = REL_DEB;
      REL_DEB: begin
        if (!rows_idle)    state_nxt = HOLD;
        else if (deb_done) state_nxt = SCAN;
      end
    endcase
  end

  // Output / datapath logic: next values of the counters, captures and the
  // registered outputs. Decisions mirror the next-state logic above.
  always_comb begin
    col_idx_nxt   = col_idx;
    col_cap_nxt   = col_cap;
    row_cap_nxt   = row_cap;
    div_cnt_nxt   = div_cnt;
    deb_cnt_nxt   = deb_cnt;
    key_col_nxt   = key_col;
    key_code_nxt  = key_code;
    key_valid_nxt = 1'b0;
    key_down_nxt  = key_down;
`ifdef KEY_REPEAT_EN
    rep_cnt_nxt   = rep_cnt;
`endif

    unique case (state)
      SCAN: begin
        if (div_done) begin
          div_cnt_nxt = '0;
          if (rows_idle) begin
            col_idx_nxt = col_idx + 2'd1;
            key_col_nxt = col_drive(col_idx + 2'd1);
          end else begin
            // Column stays driven so the debounce watches the same key.
            row_cap_nxt = row_s;
            col_cap_nxt = col_idx;
            deb_cnt_nxt = '0;
          end
        end else begin
          div_cnt_nxt = div_cnt + 1'b1;
        end
      end

      PRESS_DEB: begin
        if (!rows_match) begin
          // Bounce: rescan the same column from the start of its dwell.
          div_cnt_nxt = '0;
        end else if (deb_done) begin
          key_code_nxt  = {lowest_low_row(row_cap), col_cap};
          key_valid_nxt = 1'b1;
          key_down_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_cnt_nxt   = '0;
`endif
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (rows_idle) begin
          deb_cnt_nxt = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_done) begin
          key_valid_nxt = 1'b1;
          rep_cnt_nxt   = '0;
        end else begin
          rep_cnt_nxt = rep_cnt + 1'b1;
        end
`endif
      end

      REL_DEB: begin
        if (!rows_idle) begin
          // Release glitch: back to HOLD without a new strobe; the repeat
          // interval restarts from zero.
`ifdef KEY_REPEAT_EN
          rep_cnt_nxt = '0;
`endif
        end else if (deb_done) begin
          key_down_nxt = 1'b0;
          col_idx_nxt  = 2'd0;
          key_col_nxt  = COL0_DRV;
          div_cnt_nxt  = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_idx   <= 2'd0;
      col_cap   <= 2'd0;
      row_cap   <= ROWS_IDLE;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      key_col   <= COL0_DRV;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      col_idx   <= col_idx_nxt;
      col_cap   <= col_cap_nxt;
      row_cap   <= row_cap_nxt;
      div_cnt   <= div_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      key_col   <= key_col_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      key_down  <= key_down_nxt;
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// ---------------------------------------------------------------------------
// tb_key_scan: self-checking bench for key_scan.
//
// A keypad model turns a set of pressed keys (bit r*4+c) into row levels from
// the DUT's column drive, with overrides for bounce and glitches. Stimulus
// pushes expected key codes and strobe cycle numbers into a scoreboard queue;
// an independent monitor pops and compares on every key_valid.
// Defining KEY_REPEAT_EN for the bench as well adds the expected repeat
// strobes to the scoreboard.
// ---------------------------------------------------------------------------
module tb_key_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 8;
  localparam int REPEAT_CYC = 32;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] pressed    = '0;
  logic [3:0]  force_high = '0;
  logic [3:0]  force_low  = '0;

  int cyc            = 0;
  int checks         = 0;
  int errors         = 0;
  int n_pulses       = 0;
  int last_valid_cyc = -1;

  typedef struct {
    logic [3:0] code;
    int         stamp;   // cycle of the expected strobe, -1 when untimed
  } exp_t;

  exp_t sb_q[$];

  key_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEBOUNCE  (DEBOUNCE),
    .REPEAT_CYC(REPEAT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
      end
      if (force_high[r]) key_row[r] = 1'b1;
      if (force_low[r])  key_row[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (key_valid) begin
      exp_t e;
      n_pulses++;
      last_valid_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: key_code=%0d at cycle %0d, no strobe expected",
                 key_code, cyc);
      end else begin
        e = sb_q.pop_front();
        check("valid_code", 32'(key_code), 32'(e.code));
        if (e.stamp >= 0) check("valid_cycle", cyc, e.stamp);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return 4'b1111 ^ (one << c);
  endfunction

  // Reference: the scan meets the lowest pressed column first; in that
  // column the lowest pressed row wins.
  function automatic int expected_code(input logic [15:0] keys, output int col);
    col = -1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4+c]) begin
          col = c;
          return r * 4 + c;
        end
      end
    end
    return -1;
  endfunction

  // Returns at the cycle column 0 has just started its dwell.
  task automatic wait_col0_start();
    logic [3:0] prev;
    prev = key_col;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key_col == 4'b1110 && prev != 4'b1110) return;
      prev = key_col;
    end
    checks++;
    errors++;
    $display("FAIL col0_timeout: scan never restarted column 0, key_col=%b", key_col);
  endtask

  // Press a key set at the start of a column-0 dwell and post the
  // expectation. Timed latency: one dwell per column up to the pressed one,
  // then DEBOUNCE matching cycles.
  task automatic press_aligned(input logic [15:0] keys, input bit timed,
                               output int code, output int col);
    int stamp;
    wait_col0_start();
    code    = expected_code(keys, col);
    pressed = keys;
    stamp   = timed ? cyc + SCAN_DIV * (col + 1) + DEBOUNCE : -1;
    sb_q.push_back('{code: 4'(code), stamp: stamp});
  endtask

  task automatic wait_pulse(output int stamp);
    int base;
    base  = n_pulses;
    stamp = -1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (n_pulses != base) begin
        stamp = last_valid_cyc;
        break;
      end
    end
    if (stamp < 0) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout: no key_valid within 400 cycles");
    end
  endtask

  // Hold the key hold_cyc cycles past its first strobe, release (optionally
  // with a 2-cycle low glitch mid release-debounce) and check the release.
  // Release latency: 2 synchroniser cycles, 1 to leave HOLD, DEBOUNCE high.
  task automatic hold_release(input int code, input int col, input int stamp,
                              input int hold_cyc, input bit glitch);
    int rel;
    int fall;
    if (stamp < 0) begin
      pressed = '0;
      return;
    end
    check("down_after_press", 32'(key_down), 32'd1);
    check("col_frozen_press", 32'(key_col), 32'(col_pat(col)));
`ifdef KEY_REPEAT_EN
    for (int k = 1; k * REPEAT_CYC <= hold_cyc + 2; k++)
      sb_q.push_back('{code: 4'(code), stamp: stamp + k * REPEAT_CYC});
`else
    if (code < 0) $display("note: negative code %0d", code);
`endif
    while (cyc < stamp + hold_cyc) tick();
    check("col_frozen_hold", 32'(key_col), 32'(col_pat(col)));
    pressed = '0;
    rel = cyc;
    if (glitch) begin
      repeat (6) tick();
      force_low = 4'b0001;
      repeat (2) tick();
      force_low = 4'b0000;
      check("down_through_glitch", 32'(key_down), 32'd1);
      rel = cyc;
    end
    fall = -1;
    for (int i = 0; i < 200; i++) begin
      if (!key_down) begin
        fall = cyc;
        break;
      end
      tick();
    end
    check("release_latency", fall - rel, DEBOUNCE + 3);
    check("col_after_release", 32'(key_col), 32'(4'b1110));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int code, col, stamp, t0, base;
    logic [15:0] keys;

    // 1. Reset, then idle scanning.
    repeat (3) tick();
    check("rst_key_col", 32'(key_col), 32'(4'b1110));
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    reset = 1'b0;
    t0 = cyc;
    for (int n = 0; n < 5 * SCAN_DIV; n++) begin
      check("scan_col", 32'(key_col), 32'(col_pat((cyc - t0) / SCAN_DIV % 4)));
      tick();
    end
    check("idle_key_code", 32'(key_code), 32'd0);
    check("idle_key_down", 32'(key_down), 32'd0);

    // 2. Row 1 / column 2, stable.
    press_aligned(16'(1 << 6), 1'b1, code, col);
    wait_pulse(stamp);
    hold_release(code, col, stamp, 40, 1'b0);

    // 3. Same key with bounce (3 low, 1 high) before settling.
    press_aligned(16'(1 << 6), 1'b0, code, col);
    base = n_pulses;
    for (int i = 0; i < 24; i++) begin
      force_high[1] = (i % 4 == 3);
      tick();
    end
    force_high = '0;
    check("bounce_no_valid", n_pulses - base, 0);
    wait_pulse(stamp);
    hold_release(code, col, stamp, 30, 1'b0);

    // 4. Rows 0 and 3 on column 1, release with a glitch.
    press_aligned(16'((1 << 1) | (1 << 13)), 1'b1, code, col);
    wait_pulse(stamp);
    hold_release(code, col, stamp, 20, 1'b1);

    // 5. Reset while a key is held; the key is re-detected afterwards.
    keys = 16'(1 << $urandom_range(0, 15));
    press_aligned(keys, 1'b1, code, col);
    wait_pulse(stamp);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midrst_key_col", 32'(key_col), 32'(4'b1110));
    check("midrst_key_code", 32'(key_code), 32'd0);
    check("midrst_key_valid", 32'(key_valid), 32'd0);
    check("midrst_key_down", 32'(key_down), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    sb_q.push_back('{code: 4'(code),
                     stamp: cyc + SCAN_DIV * (col + 1) + DEBOUNCE});
    wait_pulse(stamp);
    hold_release(code, col, stamp, 25, 1'b0);

    // 6. Key 15 held long enough for several repeat intervals.
    press_aligned(16'(1 << 15), 1'b1, code, col);
    wait_pulse(stamp);
    hold_release(code, col, stamp, 100, 1'b0);

    // Randomised presses: one key, sometimes a second anywhere.
    for (int t = 0; t < 10; t++) begin
      keys = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) keys = keys | 16'(1 << $urandom_range(0, 15));
      press_aligned(keys, 1'b1, code, col);
      wait_pulse(stamp);
      hold_release(code, col, stamp, int'($urandom_range(10, 80)), 1'($urandom_range(0, 1)));
    end

    repeat (10) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
